cve2_obi_arbiter: RTL and testbench
===================================

# cve2_obi_arbiter

Two-master to one-slave OBI arbiter that sits directly downstream of the core top level. It merges the core's instruction-fetch port and data port onto a single memory port. It tracks up to `MaxOutstanding` granted-but-unanswered transactions and routes each response back to the master that issued the request. It holds a stalled request stable until it is granted, as OBI requires.

## Interface
- `MaxOutstanding`, default 2: response-routing FIFO depth; legal values 1, 2, 4.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `instr_req_i` input 1, `instr_gnt_o` output 1, `instr_rvalid_o` output 1: fetch handshake.
- `instr_addr_i` input 32: fetch address.
- `instr_rdata_o` output 32, `instr_err_o` output 1: fetch response.
- `data_req_i` input 1, `data_gnt_o` output 1, `data_rvalid_o` output 1: data handshake.
- `data_we_i` input 1, `data_be_i` input 4, `data_addr_i` input 32, `data_wdata_i` input 32: data request payload.
- `data_rdata_o` output 32, `data_err_o` output 1: data response.
- `mem_req_o` output 1, `mem_gnt_i` input 1, `mem_rvalid_i` input 1: memory handshake.
- `mem_we_o` output 1, `mem_be_o` output 4, `mem_addr_o` output 32, `mem_wdata_o` output 32: memory request payload.
- `mem_rdata_i` input 32, `mem_err_i` input 1: memory response.
- `busy_o` output 1: high while any transaction is outstanding.

## Operation
- State:
  - `cnt`: outstanding count, 0..MaxOutstanding.
  - ID FIFO: 1 bit per entry, 0 = instr, 1 = data.
  - `lock_q` and `lock_id_q`: request hold.
  - `last_q`: last master granted, used in round-robin mode only.
- `full` = (`cnt` == MaxOutstanding), taken from registered state only. There is no combinational path from `mem_rvalid_i` to `mem_req_o`.
- `mem_req_o` = !`full` & (`instr_req_i` | `data_req_i`).
- Selection:
  - If `lock_q` = 1, select `lock_id_q`.
  - Otherwise arbitrate (see Configuration).
- Payload:
  - Data selected: pass the data payload through.
  - Instr selected: `mem_we_o`=0, `mem_be_o`=4'hF, `mem_wdata_o`=0, `mem_addr_o`=`instr_addr_i`.
- Grant: the selected master's gnt = `mem_gnt_i` & `mem_req_o`. The other master's gnt = 0.
- Lock: if `mem_req_o` & !`mem_gnt_i`, set `lock_q`=1 and `lock_id_q`=selected. Any handshake clears `lock_q`.
- Push: on handshake (`mem_req_o` & `mem_gnt_i`), push the selected ID into the FIFO.
- Pop: on `mem_rvalid_i`, pop the head ID.
  - Drive the matching master's rvalid for that cycle; the other master's rvalid = 0.
  - `mem_rdata_i` and `mem_err_i` go to both masters unchanged; only rvalid qualifies them.
- Same-cycle push and pop: `cnt` is unchanged and the FIFO stays ordered. This is legal when not full. When full, no push can occur.
- `mem_rvalid_i` with `cnt`==0 is a protocol violation:
  - It is ignored and `cnt` does not underflow.
  - Both master rvalids = 0.
  - An `ASSERT` fires.
- `busy_o` = (`cnt` != 0).
- Masters drop a request before its grant: the lock is released only by a handshake. OBI forbids withdrawing a request, and an assertion checks this.

## Timing
- Request path: master req → `mem_req_o` is combinational, zero cycles.
- Grant path: `mem_gnt_i` → master gnt is combinational.
- Response path: `mem_rvalid_i` → master rvalid is combinational, zero added latency.
- Register updates:
  - `cnt`, the FIFO and the lock registers update on the `clk_i` edge after the handshake or response.
  - A full FIFO deasserts `mem_req_o` from the cycle after the MaxOutstanding-th grant.
  - `mem_req_o` reasserts the cycle after the first pop.
- Reset values:
  - `cnt`=0, FIFO pointers=0, `lock_q`=0, `last_q`=instr.
  - All outputs 0 while reset is asserted with masters idle.
- Reset mid-operation: all outstanding IDs are discarded, and responses arriving after reset are treated as the empty-FIFO case.

## Configuration
- Macro `CVE2_OBI_ARB_RR_EN`.
- Undefined (default): fixed priority. When both master requests are high and unlocked, data wins. Instr can starve while data requests are back-to-back.
- Defined: round-robin.
  - When both master requests are high and unlocked, select the master ≠ `last_q`.
  - `last_q` updates on every handshake.
  - A single requester is always selected.

## Test plan
- Single fetch: `instr_req_i`=1, addr 0x80, `mem_gnt_i`=1 same cycle, `mem_rvalid_i` next cycle with rdata 0x00000013 → `instr_gnt_o`=1 in cycle 0; `instr_rvalid_o`=1 and `instr_rdata_o`=0x13 in cycle 1; `data_rvalid_o`=0; `mem_be_o`=4'hF.
- Contention: both requests high with `mem_gnt_i`=1 for 2 cycles.
  - Default build: data granted both cycles.
  - RR build: data granted, then instr.
  - Responses return in the same order, routed accordingly.
- Stall lock: both request with `mem_gnt_i`=0 for 3 cycles, then 1 → `mem_addr_o` stays equal to `data_addr_i` in all 4 cycles, and only `data_gnt_o` pulses.
- Full: MaxOutstanding=2, three back-to-back grants requested with no rvalid → `mem_req_o`=0 on the third cycle. It returns to 1 the cycle after one `mem_rvalid_i`, and `busy_o` stays 1 throughout.
- Error routing: data read at 0xFFFF_0000 answered with `mem_err_i`=1 → `data_rvalid_o`=1, `data_err_o`=1, `instr_rvalid_o`=0.
- Reset mid-operation: `rst_ni` pulsed low with 2 outstanding → after release `cnt`=0, `busy_o`=0, and a stray `mem_rvalid_i` produces no master rvalid.

Source files
------------

// File: rtl/cve2_obi_arbiter.sv
// ============================================================================
// cve2_obi_arbiter : two-master (fetch/data) to one-slave OBI arbiter, rev 1.0
// Optional round-robin arbitration via `CVE2_OBI_ARB_RR_EN (default: data wins)
// ============================================================================
`default_nettype none

module cve2_obi_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,

  output logic        busy_o
);

  localparam int unsigned c_PTR_W = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned c_DEPTH = 1 << c_PTR_W;
  localparam int unsigned c_CNT_W = $clog2(MaxOutstanding + 1);

  generate
    if (MaxOutstanding != 1 && MaxOutstanding != 2 && MaxOutstanding != 4) begin : g_param_check
      $error("cve2_obi_arbiter: MaxOutstanding must be 1, 2 or 4");
    end
  endgenerate

  logic [c_CNT_W-1:0] r_cnt;
  logic [c_DEPTH-1:0] r_fifo;
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic               r_lock;
  logic               r_lock_id;

  logic w_full;
  logic w_any_req;
  logic w_arb_id;
  logic w_sel;
  logic w_hs;
  logic w_pop;
  logic w_head;

  // Wrap at MaxOutstanding; storage is padded to a power of two for indexing.
  function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(MaxOutstanding - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  // Full is derived from registered state only, so rvalid never reaches mem_req_o.
  assign w_full    = (r_cnt == c_CNT_W'(MaxOutstanding));
  assign w_any_req = instr_req_i | data_req_i;
  assign mem_req_o = ~w_full & w_any_req;

`ifdef CVE2_OBI_ARB_RR_EN
  logic r_last;

  assign w_arb_id = (instr_req_i & data_req_i) ? ~r_last : data_req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last <= 1'b0;
    end else if (w_hs) begin
      r_last <= w_sel;
    end
  end
`else
  assign w_arb_id = data_req_i;
`endif

  // ID encoding: 0 = instr, 1 = data.
  assign w_sel  = r_lock ? r_lock_id : w_arb_id;
  assign w_hs   = mem_req_o & mem_gnt_i;
  assign w_head = r_fifo[r_rptr];
  assign w_pop  = mem_rvalid_i & (r_cnt != '0);

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (w_any_req) begin
      if (w_sel) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  assign instr_gnt_o    = w_hs & ~w_sel;
  assign data_gnt_o     = w_hs & w_sel;
  assign instr_rvalid_o = w_pop & ~w_head;
  assign data_rvalid_o  = w_pop & w_head;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;
  assign busy_o         = (r_cnt != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt     <= '0;
      r_fifo    <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
    end else begin
      if (w_hs && !w_pop) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end else if (w_pop && !w_hs) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end

      if (w_hs) begin
        r_fifo[r_wptr] <= w_sel;
        r_wptr         <= f_ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_ptr_inc(r_rptr);
      end

      // A stalled request keeps its master selected until it is granted.
      if (w_hs) begin
        r_lock <= 1'b0;
      end else if (mem_req_o) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_sel;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(mem_rvalid_i && (r_cnt == '0)))
        else $warning("cve2_obi_arbiter: rvalid with no outstanding transaction ignored");
      assert (!(r_lock && !(r_lock_id ? data_req_i : instr_req_i)))
        else $error("cve2_obi_arbiter: master withdrew a request before its grant");
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cve2_obi_arbiter.sv
// ============================================================================
// tb_cve2_obi_arbiter : vector-table bench for cve2_obi_arbiter, rev 1.0
// ============================================================================
`default_nettype none

module tb_cve2_obi_arbiter;

`ifdef CVE2_OBI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_gnt, data_rvalid, data_we, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_gnt, mem_rvalid, mem_we, mem_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cve2_obi_arbiter #(.MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
    .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_err_o(data_err),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .busy_o(busy)
  );

  typedef struct {
    bit          ireq;
    logic [31:0] iaddr;
    bit          dreq;
    bit          dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    bit          gnt;
    bit          rv;
    logic [31:0] rdata;
    bit          err;
    bit          e_mreq, e_ig, e_dg, e_irv, e_drv, e_busy;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    bit          e_we;
    logic [31:0] e_wdata;
  } vec_t;

  function automatic vec_t mk(
    input bit ireq, input logic [31:0] iaddr,
    input bit dreq, input bit dwe, input logic [3:0] dbe,
    input logic [31:0] daddr, input logic [31:0] dwdata,
    input bit gnt, input bit rv, input logic [31:0] rdata, input bit err,
    input bit e_mreq, input bit e_ig, input bit e_dg,
    input bit e_irv, input bit e_drv, input bit e_busy,
    input logic [31:0] e_addr, input logic [3:0] e_be, input bit e_we,
    input logic [31:0] e_wdata);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe; v.dbe = dbe;
    v.daddr = daddr; v.dwdata = dwdata; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.err = err; v.e_mreq = e_mreq; v.e_ig = e_ig; v.e_dg = e_dg; v.e_irv = e_irv;
    v.e_drv = e_drv; v.e_busy = e_busy; v.e_addr = e_addr; v.e_be = e_be;
    v.e_we = e_we; v.e_wdata = e_wdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    instr_req = 0; instr_addr = 0; data_req = 0; data_we = 0; data_be = 0;
    data_addr = 0; data_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
  endtask

  // Drive one cycle's inputs just after the clock edge, check mid-cycle.
  task automatic apply(input vec_t v, input string tag);
    @(posedge clk); #1;
    instr_req = v.ireq; instr_addr = v.iaddr; data_req = v.dreq; data_we = v.dwe;
    data_be = v.dbe; data_addr = v.daddr; data_wdata = v.dwdata; mem_gnt = v.gnt;
    mem_rvalid = v.rv; mem_rdata = v.rdata; mem_err = v.err;
    #3;
    chk({tag, " mem_req"},      {31'b0, mem_req},      {31'b0, v.e_mreq});
    chk({tag, " instr_gnt"},    {31'b0, instr_gnt},    {31'b0, v.e_ig});
    chk({tag, " data_gnt"},     {31'b0, data_gnt},     {31'b0, v.e_dg});
    chk({tag, " instr_rvalid"}, {31'b0, instr_rvalid}, {31'b0, v.e_irv});
    chk({tag, " data_rvalid"},  {31'b0, data_rvalid},  {31'b0, v.e_drv});
    chk({tag, " busy"},         {31'b0, busy},         {31'b0, v.e_busy});
    chk({tag, " mem_addr"},     mem_addr,              v.e_addr);
    chk({tag, " mem_be"},       {28'b0, mem_be},       {28'b0, v.e_be});
    chk({tag, " mem_we"},       {31'b0, mem_we},       {31'b0, v.e_we});
    chk({tag, " mem_wdata"},    mem_wdata,             v.e_wdata);
    if (v.rv) begin
      chk({tag, " instr_rdata"}, instr_rdata, v.rdata);
      chk({tag, " data_rdata"},  data_rdata,  v.rdata);
      chk({tag, " instr_err"},   {31'b0, instr_err}, {31'b0, v.err});
      chk({tag, " data_err"},    {31'b0, data_err},  {31'b0, v.err});
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_req"},      {31'b0, mem_req},      32'h0);
    chk({tag, " instr_gnt"},    {31'b0, instr_gnt},    32'h0);
    chk({tag, " data_gnt"},     {31'b0, data_gnt},     32'h0);
    chk({tag, " instr_rvalid"}, {31'b0, instr_rvalid}, 32'h0);
    chk({tag, " data_rvalid"},  {31'b0, data_rvalid},  32'h0);
    chk({tag, " busy"},         {31'b0, busy},         32'h0);
    chk({tag, " mem_addr"},     mem_addr,              32'h0);
    chk({tag, " mem_be"},       {28'b0, mem_be},       32'h0);
    chk({tag, " mem_wdata"},    mem_wdata,             32'h0);
  endtask

  vec_t tbl[20];
  vec_t fl[8];
  vec_t d1;

  initial begin
    // Single fetch, contention, error routing, stall locks.
    tbl[0]  = mk(0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0);
    tbl[1]  = mk(1,32'h80, 0,0,0,0,0, 1,0,0,0, 1,1,0,0,0,0, 32'h80,4'hF,0,0);
    tbl[2]  = mk(0,0, 0,0,0,0,0, 0,1,32'h13,0, 0,0,0,1,0,1, 0,0,0,0);
    tbl[3]  = mk(1,32'h100, 1,1,4'h3,32'h2000,32'hDEADBEEF, 1,0,0,0,
                 1,0,1,0,0,0, 32'h2000,4'h3,1,32'hDEADBEEF);
    tbl[4]  = RR ? mk(1,32'h100, 1,1,4'h3,32'h2000,32'hDEADBEEF, 1,0,0,0,
                      1,1,0,0,0,1, 32'h100,4'hF,0,0)
                 : mk(1,32'h100, 1,1,4'h3,32'h2000,32'hDEADBEEF, 1,0,0,0,
                      1,0,1,0,0,1, 32'h2000,4'h3,1,32'hDEADBEEF);
    tbl[5]  = mk(0,0, 0,0,0,0,0, 0,1,32'hA,0, 0,0,0,0,1,1, 0,0,0,0);
    tbl[6]  = mk(0,0, 0,0,0,0,0, 0,1,32'hB,0, 0,0,0,RR,!RR,1, 0,0,0,0);
    tbl[7]  = mk(0,0, 1,0,4'hF,32'hFFFF0000,0, 1,0,0,0, 1,0,1,0,0,0, 32'hFFFF0000,4'hF,0,0);
    tbl[8]  = mk(0,0, 0,0,0,0,0, 0,1,32'h0,1, 0,0,0,0,1,1, 0,0,0,0);
    for (int i = 9; i < 12; i++)
      tbl[i] = mk(1,32'h300, 1,1,4'hF,32'h4000,32'h55, 0,0,0,0, 1,0,0,0,0,0,
                  RR ? 32'h300 : 32'h4000, 4'hF, !RR, RR ? 32'h0 : 32'h55);
    tbl[12] = mk(1,32'h300, 1,1,4'hF,32'h4000,32'h55, 1,0,0,0, 1,RR,!RR,0,0,0,
                 RR ? 32'h300 : 32'h4000, 4'hF, !RR, RR ? 32'h0 : 32'h55);
    tbl[13] = mk(0,0, 0,0,0,0,0, 0,1,32'h77,0, 0,0,0,RR,!RR,1, 0,0,0,0);
    tbl[14] = mk(1,32'h500, 0,0,0,0,0, 0,0,0,0, 1,0,0,0,0,0, 32'h500,4'hF,0,0);
    tbl[15] = mk(1,32'h500, 1,1,4'hF,32'h6000,32'h99, 0,0,0,0, 1,0,0,0,0,0, 32'h500,4'hF,0,0);
    tbl[16] = mk(1,32'h500, 1,1,4'hF,32'h6000,32'h99, 1,0,0,0, 1,1,0,0,0,0, 32'h500,4'hF,0,0);
    tbl[17] = mk(0,0, 1,1,4'hF,32'h6000,32'h99, 1,0,0,0, 1,0,1,0,0,1, 32'h6000,4'hF,1,32'h99);
    tbl[18] = mk(0,0, 0,0,0,0,0, 0,1,32'h1,0, 0,0,0,1,0,1, 0,0,0,0);
    tbl[19] = mk(0,0, 0,0,0,0,0, 0,1,32'h2,0, 0,0,0,0,1,1, 0,0,0,0);

    // Full FIFO: third request blocked, released the cycle after one response.
    fl[0] = mk(0,0, 1,0,4'hF,32'h10,0, 1,0,0,0, 1,0,1,0,0,0, 32'h10,4'hF,0,0);
    fl[1] = mk(0,0, 1,0,4'hF,32'h10,0, 1,0,0,0, 1,0,1,0,0,1, 32'h10,4'hF,0,0);
    fl[2] = mk(0,0, 1,0,4'hF,32'h10,0, 1,0,0,0, 0,0,0,0,0,1, 32'h10,4'hF,0,0);
    fl[3] = mk(0,0, 1,0,4'hF,32'h10,0, 1,1,32'h21,0, 0,0,0,0,1,1, 32'h10,4'hF,0,0);
    fl[4] = mk(0,0, 1,0,4'hF,32'h10,0, 1,0,0,0, 1,0,1,0,0,1, 32'h10,4'hF,0,0);
    fl[5] = mk(0,0, 0,0,0,0,0, 0,1,32'h22,0, 0,0,0,0,1,1, 0,0,0,0);
    fl[6] = mk(0,0, 0,0,0,0,0, 0,1,32'h23,0, 0,0,0,0,1,1, 0,0,0,0);
    fl[7] = mk(0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0);

    drive_idle();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_ni = 1'b1;

    for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 8; i++)  apply(fl[i],  $sformatf("full%0d", i));

    // Reset with two transactions outstanding, then a stray response.
    apply(fl[0], "rst_fill0");
    apply(fl[1], "rst_fill1");
    @(posedge clk); #1;
    drive_idle();
    rst_ni = 1'b0;
    #3;
    chk_all_zero("midreset");
    @(posedge clk); #1;
    rst_ni = 1'b1;
    d1 = mk(0,0, 0,0,0,0,0, 0,1,32'h44,0, 0,0,0,0,0,0, 0,0,0,0);
    apply(d1, "stray_rvalid");
    apply(fl[7], "post_reset_idle");
    d1 = mk(1,32'hC0, 0,0,0,0,0, 1,0,0,0, 1,1,0,0,0,0, 32'hC0,4'hF,0,0);
    apply(d1, "post_reset_fetch");
    d1 = mk(0,0, 0,0,0,0,0, 0,1,32'h55,0, 0,0,0,1,0,1, 0,0,0,0);
    apply(d1, "post_reset_resp");

    @(posedge clk); #1;
    drive_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
